trng_collector: RTL and testbench
=================================

# trng_collector

Parametrised entropy collector for the TRNG tile: samples N_CH free-running entropy sources, XOR-combines the enabled channels, and optionally applies von Neumann debiasing. It runs a repetition-count health test, packs accepted bits into WORD_W-bit words, and presents them on a one-deep valid/ready output register. It sits between the analog/ring-oscillator entropy cells and the tile's output pins or readout logic.

## Interface
- N_CH, 4: entropy channels, 1..16
- WORD_W, 8: output word width, 8..64
- SAMPLE_DIV, 1: clk cycles per sample tick, ≥1
- REP_LIMIT, 16: identical consecutive raw bits that trip the health test, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  collector enable; low clears all state except configuration inputs
- ent_in  in  N_CH  raw entropy, asynchronous to clk
- ch_mask  in  N_CH  1 = channel included in XOR
- rd_data  out  WORD_W  output word
- rd_valid  out  1  rd_data holds an unread word
- rd_ready  in  1  consumer accepts word
- health_fail  out  1  sticky health-test failure

## Operation
- Each ent_in bit passes through a 2-FF synchroniser; synchroniser flops are reset to 0.
- Divider: counts 0..SAMPLE_DIV-1 while en=1; tick in the cycle count==SAMPLE_DIV-1, then wrap to 0. Held at 0 while en=0.
- On tick: raw = XOR of synchronised channels with ch_mask=1. If ch_mask=0, raw=0.
- Health: rep_cnt, width $clog2(REP_LIMIT+1). First tick after entering FILL sets rep_cnt=1. Later ticks increment rep_cnt if raw equals the previous raw, else set it to 1. rep_cnt reaching REP_LIMIT -> FAIL.
- Accepted bit: raw in every tick (see Configuration). Bits shift in at LSB, so the first accepted bit ends at MSB.
- Assembler: shift register plus bit count 0..WORD_W.
  - The edge capturing bit WORD_W loads the word into the holding register if rd_valid=0 or rd_valid&rd_ready in that cycle; the count resets to 0.
  - Otherwise the assembler holds its full word and drops new accepted bits. It loads on the edge after the handshake that frees the holding register.
- Handshake: transfer when rd_valid&rd_ready. rd_data is stable while rd_valid&!rd_ready.
- States:
  - IDLE (en=0): everything cleared, including rd_valid, rd_data, divider, rep_cnt, the VN pair, the assembler and health_fail. en=1 -> FILL.
  - FILL: normal collection. Health trip -> FAIL. en=0 -> IDLE.
  - FAIL: health_fail=1; holding register and assembler flushed, rd_valid=0, ticks ignored. Only en=0 (≥1 cycle) -> IDLE clears it.
- Simultaneous health trip and word completion: the trip wins; the word is discarded.

## Timing
- All outputs are 0 during and after reset.
- Sync latency: 2 cycles from ent_in to raw.
- With SAMPLE_DIV=1, raw mode, rd_ready=1: the first tick is the cycle after en rises. rd_valid rises 1 cycle after the tick carrying bit WORD_W.
- health_fail asserts the cycle after the tripping tick's edge.
- rd_valid falls the cycle after a transfer unless the same edge loads a new word.
- en falling: IDLE takes effect at the next edge; any pending word is lost.

## Configuration
- TRNG_VN_DEBIAS_EN defined:
  - Raw bits are paired: the first tick of a pair stores raw, the second resolves it.
  - 01 -> accept 0; 10 -> accept 1; 00/11 -> discard.
  - The pair register is cleared in IDLE/FAIL.
- Undefined: every raw bit is accepted; no pair register.
- The health test always operates on raw bits, before debiasing.

## Structure
- Package trng_pkg: state enum (IDLE, FILL, FAIL), localparam for synchroniser depth (2), and the rep_cnt width function.
- Sub-module trng_sync2: parameterised N-bit 2-FF synchroniser with async active-low reset, instantiated once for ent_in.

## Test plan
Parameters N_CH=4, WORD_W=8, SAMPLE_DIV=1, REP_LIMIT=16 unless noted.
- Raw mode, ch_mask=4'b0001, ent_in[0] = 1,0,1,1,0,0,1,0 per tick, rd_ready=1 -> one word rd_data=8'hB2, rd_valid high 1 cycle.
- TRNG_VN_DEBIAS_EN, raw pairs 01,10,00,11,10,10,01,01,10,01 -> accepted 0,1,1,1,0,0,1,0 -> rd_data=8'h72.
- ch_mask=4'b0011, ent_in[0]=1 constant, ent_in[1] alternating 0/1 -> raw alternates 1/0 -> rd_data=8'hAA, health_fail stays 0.
- ent_in constant, ch_mask=4'b0001 -> health_fail=1 after tick 16, rd_valid=0, no further words. en low 1 cycle -> health_fail=0.
- rd_ready=0 for 30 ticks -> rd_valid=1 with the first word stable. Second word held in the assembler; bits 17..30 dropped. rd_ready pulse -> second word appears next cycle.
- rst_n low after 5 bits of a word -> all outputs 0 immediately. On release with en=1, the next word contains only post-reset bits.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG entropy collector.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FAIL
    } state_e;

    localparam int SYNC_STAGES = 2;

    // Width that holds a repetition count up to and including the trip limit.
    function automatic int rep_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/trng_sync2.sv
// N-bit multi-flop synchroniser for asynchronous entropy inputs; flops reset to 0.
module trng_sync2
    import trng_pkg::*;
#(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/trng_collector.sv
// Entropy collector: sync, XOR-combine, health test, word assembly, one-deep output.
// Optional von Neumann debiasing is built when TRNG_VN_DEBIAS_EN is defined.
module trng_collector
    import trng_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WORD_W     = 8,
    parameter int SAMPLE_DIV = 1,
    parameter int REP_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_CH-1:0]   ent_in,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int REP_W = rep_cnt_w(REP_LIMIT);
    localparam int CNT_W = $clog2(WORD_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [REP_W-1:0] REP_TRIP  = REP_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1);

    logic [N_CH-1:0]   ent_sync;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              prev_q, prev_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
`ifdef TRNG_VN_DEBIAS_EN
    logic              vn_have_q, vn_have_d;
    logic              vn_bit_q, vn_bit_d;
`endif

    logic              tick;
    logic              raw;
    logic              acc_vld;
    logic              acc_bit;
    logic [REP_W-1:0]  rep_next;
    logic              trip;
    logic              hold_free;
    logic [WORD_W-1:0] shifted;

    trng_sync2 #(.N(N_CH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ent_in),
        .q_o   (ent_sync)
    );

    assign tick     = (state_q == FILL) && (div_q == DIV_LAST);
    assign raw      = ^(ent_sync & ch_mask);
    // rep_q of 0 marks the first tick since entering FILL.
    assign rep_next = ((rep_q == '0) || (raw != prev_q)) ? REP_W'(1) : rep_q + REP_W'(1);
    assign trip     = tick && (rep_next == REP_TRIP);

`ifdef TRNG_VN_DEBIAS_EN
    assign acc_vld = tick && vn_have_q && (vn_bit_q != raw);
    assign acc_bit = vn_bit_q;
`else
    assign acc_vld = tick;
    assign acc_bit = raw;
`endif

    assign hold_free = !valid_q || rd_ready;
    assign shifted   = {shift_q[WORD_W-2:0], acc_bit};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rep_d   = rep_q;
        prev_d  = prev_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef TRNG_VN_DEBIAS_EN
        vn_have_d = vn_have_q;
        vn_bit_d  = vn_bit_q;
`endif

        case (state_q)
            IDLE:    state_d = en ? FILL : IDLE;
            FILL:    state_d = !en ? IDLE : (trip ? FAIL : FILL);
            FAIL:    state_d = en ? FAIL : IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == FILL) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                rep_d  = rep_next;
                prev_d = raw;
`ifdef TRNG_VN_DEBIAS_EN
                vn_have_d = !vn_have_q;
                vn_bit_d  = raw;
`endif
            end
            if (valid_q && rd_ready) begin
                valid_d = 1'b0;
            end
            // A full assembler waits for the holding register; bits arriving meanwhile are dropped.
            if (cnt_q == CNT_FULL) begin
                if (hold_free) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end else if (acc_vld) begin
                shift_d = shifted;
                if (cnt_q == CNT_LAST) begin
                    if (hold_free) begin
                        data_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CNT_FULL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Leaving or staying out of FILL, or a health trip, wipes the whole datapath.
        if ((state_d != FILL) || (state_q != FILL)) begin
            div_d   = '0;
            rep_d   = '0;
            prev_d  = 1'b0;
            shift_d = '0;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            vn_have_d = 1'b0;
            vn_bit_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            rep_q   <= '0;
            prev_q  <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            vn_have_q <= 1'b0;
            vn_bit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rep_q   <= rep_d;
            prev_q  <= prev_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef TRNG_VN_DEBIAS_EN
            vn_have_q <= vn_have_d;
            vn_bit_q  <= vn_bit_d;
`endif
        end
    end

    assign rd_data     = data_q;
    assign rd_valid    = valid_q;
    assign health_fail = (state_q == FAIL);

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector (N_CH=4, WORD_W=8, SAMPLE_DIV=1, REP_LIMIT=16).
module tb_trng_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] ent_in;
    logic [3:0] ch_mask;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       health_fail;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] stim [0:63];
    int         stim_len = 1;

    trng_collector #(
        .N_CH       (4),
        .WORD_W     (8),
        .SAMPLE_DIV (1),
        .REP_LIMIT  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ent_in      (ent_in),
        .ch_mask     (ch_mask),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Serial bit stream on channel 0, first bit first.
    task automatic load_bits(input logic [63:0] b, input int n);
        for (int j = 0; j < n; j++) begin
            stim[j] = {3'b000, b[n-1-j]};
        end
        stim_len = n;
    endtask

    // Step i of a run: stim[i] feeds tick i+1 (two sync flops of lead), en rises at step 1.
    task automatic cyc(input int i);
        @(negedge clk);
        ent_in = (i < stim_len) ? stim[i] : stim[stim_len-1];
        en     = (i >= 1);
    endtask

    task automatic gap();
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        ent_in   = 4'h0;
        ch_mask  = 4'b0001;
        rd_ready = 1'b1;
        #12;
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_health", health_fail, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef TRNG_VN_DEBIAS_EN
        // Raw word 1,0,1,1,0,0,1,0 -> B2, visible for one cycle
        ch_mask  = 4'b0001;
        rd_ready = 1'b1;
        load_bits(64'hB2, 8);
        for (int i = 0; i <= 11; i++) begin
            cyc(i);
            if (i == 9)  check("raw_before_valid", rd_valid, 1'b0);
            if (i == 10) check("raw_valid", rd_valid, 1'b1);
            if (i == 10) check("raw_data_B2", rd_data, 8'hB2);
            if (i == 11) check("raw_valid_drop", rd_valid, 1'b0);
        end
        gap();

        // Two-channel XOR with alternating channel 1 -> AA words, no health trip
        ch_mask = 4'b0011;
        for (int j = 0; j < 24; j++) begin
            stim[j] = {2'b00, (j % 2 == 1), 1'b1};
        end
        stim_len = 24;
        for (int i = 0; i <= 23; i++) begin
            cyc(i);
            if (i == 10) check("xor_word1", rd_data, 8'hAA);
            if (i == 18) check("xor_word2", rd_data, 8'hAA);
            if (i == 18) check("xor_valid2", rd_valid, 1'b1);
        end
        check("xor_no_health", health_fail, 1'b0);
        gap();
`endif

        // Constant raw bit trips the health test at tick 16
        ch_mask  = 4'b0001;
        rd_ready = 1'b1;
        stim[0]  = 4'b0001;
        stim_len = 1;
        for (int i = 0; i <= 28; i++) begin
            cyc(i);
`ifndef TRNG_VN_DEBIAS_EN
            if (i == 10) check("hf_word1", rd_data, 8'hFF);
`else
            if (i == 10) check("hf_vn_no_word", rd_valid, 1'b0);
`endif
            if (i == 17) check("hf_before_trip", health_fail, 1'b0);
            if (i == 18) check("hf_tripped", health_fail, 1'b1);
            if (i == 18) check("hf_word_discarded", rd_valid, 1'b0);
            if (i == 28) check("hf_no_more_words", rd_valid, 1'b0);
        end
        check("hf_sticky", health_fail, 1'b1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("hf_cleared", health_fail, 1'b0);
        gap();

`ifdef TRNG_VN_DEBIAS_EN
        // Raw pairs 01,10,00,11,10,10,01,01,10,01 -> 0,1,1,1,0,0,1,0 -> 72
        ch_mask  = 4'b0001;
        rd_ready = 1'b1;
        load_bits(64'h63A59, 20);
        for (int i = 0; i <= 23; i++) begin
            cyc(i);
            if (i == 21) check("vn_before_valid", rd_valid, 1'b0);
            if (i == 22) check("vn_valid", rd_valid, 1'b1);
            if (i == 22) check("vn_data_72", rd_data, 8'h72);
            if (i == 23) check("vn_valid_drop", rd_valid, 1'b0);
        end
        gap();
`else
        // Back-pressure: first word held stable, second parked, bits 17..30 dropped
        ch_mask  = 4'b0001;
        rd_ready = 1'b0;
        load_bits({8'h3C, 8'h96, 14'h2AAA, 10'h2AA}, 40);
        for (int i = 0; i <= 34; i++) begin
            cyc(i);
            if (i == 10) check("bp_first_word", rd_data, 8'h3C);
            if (i == 20) check("bp_stable_20", rd_data, 8'h3C);
            if (i == 31) check("bp_stable_31", rd_data, 8'h3C);
            if (i == 31) check("bp_valid_31", rd_valid, 1'b1);
            if (i == 32) rd_ready = 1'b1;
            if (i == 33) begin
                rd_ready = 1'b0;
                check("bp_second_valid", rd_valid, 1'b1);
                check("bp_second_word", rd_data, 8'h96);
            end
            if (i == 34) check("bp_second_stable", rd_data, 8'h96);
        end
        gap();

        // Async reset mid-word with a pending output word
        rd_ready = 1'b0;
        load_bits({8'hC3, 5'b10110}, 13);
        for (int i = 0; i <= 14; i++) begin
            cyc(i);
            if (i == 10) check("rst_pending_word", rd_data, 8'hC3);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", rd_valid, 1'b0);
        check("rst_async_data", rd_data, 8'h00);
        check("rst_async_health", health_fail, 1'b0);
        repeat (2) @(negedge clk);
        rd_ready = 1'b1;
        load_bits(64'h5A, 8);
        for (int i = 0; i <= 10; i++) begin
            cyc(i);
            if (i == 1) rst_n = 1'b1;
            if (i == 9)  check("post_rst_no_early", rd_valid, 1'b0);
            if (i == 10) check("post_rst_word", rd_data, 8'h5A);
        end
        gap();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
